// File: rtl/req_pkg.sv
// Shared constants for the request-capture stage and the downstream 16-input priority encoder.
package req_pkg;

    localparam int N_REQ       = 16;
    localparam int IDX_W       = 4;
    localparam int SYNC_STAGES = 2;

    localparam logic [N_REQ-1:0] MASK_RST = {N_REQ{1'b1}};

    // Encoder "no request" code, kept here so encoder and consumers agree on it
    localparam logic [7:0] ENC_NONE = 8'hF0;

endpackage

// File: rtl/req_sync_edge.sv
// Multi-flop synchroniser per request line followed by a rising-edge detector.
module req_sync_edge #(
    parameter int W      = 16,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] async_in,
    output logic [W-1:0] rise
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [STAGES-1:0][W-1:0] sync_d;
    logic [W-1:0]             prev_q;
    logic [W-1:0]             prev_d;

    // Shift chain and edge detect; runs every cycle regardless of capture enable
    always_comb begin
        sync_d[0] = async_in;
        for (int s = 1; s < STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        prev_d = sync_q[STAGES-1];
        rise   = sync_q[STAGES-1] & ~prev_q;
    end

    // Synchroniser and previous-value registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {(STAGES*W){1'b0}};
            prev_q <= {W{1'b0}};
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

endmodule

// File: rtl/req_pending_latch.sv
// Sticky pending/overflow capture of synchronised request edges, masked onto the encoder input.
module req_pending_latch #(
    parameter int N_REQ       = req_pkg::N_REQ,
    parameter int IDX_W       = req_pkg::IDX_W,
    parameter int SYNC_STAGES = req_pkg::SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_REQ-1:0] req_in,
    input  logic             mask_we,
    input  logic [N_REQ-1:0] mask_wdata,
    input  logic             clr_valid,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             clr_all,
    input  logic             ovf_clr,
    output logic [N_REQ-1:0] pend_vec,
    output logic             pend_any,
    output logic [N_REQ-1:0] ovf_vec
);

    logic [N_REQ-1:0] rise_s;
    logic [N_REQ-1:0] set_s;
    logic [N_REQ-1:0] clr_s;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] ovf_q;
    logic [N_REQ-1:0] ovf_d;
    logic [N_REQ-1:0] mask_q;
    logic [N_REQ-1:0] mask_d;

    // Indices at or above N_REQ match no bit, so they decode to an empty vector
    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx,
                                                    input logic             vld);
        logic [N_REQ-1:0] oh;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = vld & ({1'b0, idx} == (IDX_W+1)'(i));
        end
        return oh;
    endfunction

    req_sync_edge #(
        .W      (N_REQ),
        .STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (req_in),
        .rise     (rise_s)
    );

    // Next-state: a set in the same cycle as a clear wins so no event is lost
    always_comb begin
        clr_s     = clr_all ? {N_REQ{1'b1}} : idx_onehot(clr_idx, clr_valid);
        set_s     = rise_s & {N_REQ{ena}};
        pending_d = (pending_q & ~clr_s) | set_s;
        ovf_d     = (ovf_clr ? {N_REQ{1'b0}} : ovf_q) | (set_s & pending_q & ~clr_s);
        mask_d    = mask_we ? mask_wdata : mask_q;
    end

    // Pending, overflow and mask registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_q <= {N_REQ{1'b0}};
            ovf_q     <= {N_REQ{1'b0}};
            mask_q    <= {N_REQ{1'b1}};
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            mask_q    <= mask_d;
        end
    end

    assign pend_vec = pending_q & mask_q;
    assign pend_any = |pend_vec;
    assign ovf_vec  = ovf_q;

endmodule

// File: tb/tb_req_pending_latch.sv
// Scoreboard bench for req_pending_latch: a cycle model pushes expectations, DUT outputs pop them.
module tb_req_pending_latch;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic [15:0] req_in;
    logic        mask_we;
    logic [15:0] mask_wdata;
    logic        clr_valid;
    logic [3:0]  clr_idx;
    logic        clr_all;
    logic        ovf_clr;
    logic [15:0] pend_vec;
    logic        pend_any;
    logic [15:0] ovf_vec;

    typedef struct {
        logic [15:0] pend;
        logic        any;
        logic [15:0] ovf;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec;
    int   n_err;

    // Reference model state (two synchroniser stages)
    logic [15:0] m_s1, m_s2, m_prev, m_pend, m_ovf, m_mask;

    req_pending_latch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req_in     (req_in),
        .mask_we    (mask_we),
        .mask_wdata (mask_wdata),
        .clr_valid  (clr_valid),
        .clr_idx    (clr_idx),
        .clr_all    (clr_all),
        .ovf_clr    (ovf_clr),
        .pend_vec   (pend_vec),
        .pend_any   (pend_any),
        .ovf_vec    (ovf_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently driven
    task automatic model_step();
        logic [15:0] rise;
        exp_t e;
        if (!rst_n) begin
            m_s1 = 16'h0; m_s2 = 16'h0; m_prev = 16'h0;
            m_pend = 16'h0; m_ovf = 16'h0; m_mask = 16'hFFFF;
        end else begin
            rise = m_s2 & ~m_prev;
            for (int i = 0; i < 16; i++) begin
                bit clr_i, set_i;
                clr_i = clr_all || (clr_valid && (int'(clr_idx) == i));
                set_i = rise[i] && ena;
                if (set_i && m_pend[i] && !clr_i) m_ovf[i] = 1'b1;
                else if (ovf_clr)                 m_ovf[i] = 1'b0;
                if (set_i)      m_pend[i] = 1'b1;
                else if (clr_i) m_pend[i] = 1'b0;
            end
            if (mask_we) m_mask = mask_wdata;
            m_prev = m_s2;
            m_s2   = m_s1;
            m_s1   = req_in;
        end
        e.pend = m_pend & m_mask;
        e.any  = (e.pend != 16'h0);
        e.ovf  = m_ovf;
        sb_q.push_back(e);
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_empty: got 0 entries expected 1");
            end else begin
                e = sb_q.pop_front();
                chk("sb_pend", pend_vec, e.pend);
                chk("sb_any", {15'd0, pend_any}, {15'd0, e.any});
                chk("sb_ovf", ovf_vec, e.ovf);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        m_s1 = 16'h0; m_s2 = 16'h0; m_prev = 16'h0;
        m_pend = 16'h0; m_ovf = 16'h0; m_mask = 16'hFFFF;
        rst_n = 1'b0; ena = 1'b1; req_in = 16'hFFFF; mask_we = 1'b0; mask_wdata = 16'h0;
        clr_valid = 1'b0; clr_idx = 4'h0; clr_all = 1'b0; ovf_clr = 1'b0;
        @(negedge clk);

        // Reset with all requests high; held level counts as a new event after release
        tick(2);
        chk("rst_pend", pend_vec, 16'h0);
        chk("rst_ovf", ovf_vec, 16'h0);
        chk("rst_any", {15'd0, pend_any}, 16'h0);
        rst_n = 1'b1;
        tick(2);
        chk("rel_early", pend_vec, 16'h0);
        tick(1);
        chk("rel_pend", pend_vec, 16'hFFFF);
        req_in = 16'h0; clr_all = 1'b1;
        tick(1);
        clr_all = 1'b0;
        tick(3);

        // Capture and clear on bit 5
        req_in = 16'h0020;
        tick(2);
        chk("cap_early", pend_vec, 16'h0);
        tick(1);
        chk("cap_pend", pend_vec, 16'h0020);
        chk("cap_any", {15'd0, pend_any}, 16'h0001);
        tick(3);
        chk("hold_pend", pend_vec, 16'h0020);
        chk("hold_ovf", ovf_vec, 16'h0);
        clr_valid = 1'b1; clr_idx = 4'd5;
        tick(1);
        chk("clr_pend", pend_vec, 16'h0);
        clr_valid = 1'b0; req_in = 16'h0;
        tick(3);

        // Set/clear collision on bit 3, then an index that selects an idle bit
        req_in = 16'h0008;
        tick(3);
        req_in = 16'h0;
        tick(3);
        req_in = 16'h0008;
        tick(2);
        clr_valid = 1'b1; clr_idx = 4'd3;
        tick(1);
        chk("coll_pend", pend_vec, 16'h0008);
        chk("coll_ovf", ovf_vec, 16'h0);
        clr_idx = 4'hF;
        tick(1);
        chk("idx15_pend", pend_vec, 16'h0008);
        clr_valid = 1'b0;

        // Overflow on bit 0 and its clear
        req_in = 16'h0009;
        tick(3);
        req_in = 16'h0008;
        tick(3);
        req_in = 16'h0009;
        tick(3);
        chk("ovf_set", ovf_vec, 16'h0001);
        ovf_clr = 1'b1;
        tick(1);
        chk("ovf_clr", ovf_vec, 16'h0);
        chk("ovf_pend", pend_vec & 16'h0001, 16'h0001);
        ovf_clr = 1'b0; clr_all = 1'b1; req_in = 16'h0;
        tick(1);
        clr_all = 1'b0;
        tick(3);

        // Masked capture, then unmask exposes it immediately
        mask_we = 1'b1; mask_wdata = 16'h00FF;
        tick(1);
        mask_we = 1'b0; req_in = 16'h1000;
        tick(3);
        chk("mask_pend", pend_vec, 16'h0);
        chk("mask_any", {15'd0, pend_any}, 16'h0);
        mask_we = 1'b1; mask_wdata = 16'hFFFF;
        tick(1);
        chk("unmask", pend_vec, 16'h1000);
        mask_we = 1'b0; clr_all = 1'b1; req_in = 16'h0;
        tick(1);
        clr_all = 1'b0;
        tick(3);

        // Rise while disabled is dropped
        ena = 1'b0; req_in = 16'h0080;
        tick(4);
        ena = 1'b1;
        tick(3);
        chk("ena_drop", pend_vec, 16'h0);
        req_in = 16'h0;
        tick(3);

        // Reset mid-operation loses pending state
        req_in = 16'h0204;
        tick(3);
        chk("pre_rst", pend_vec, 16'h0204);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst", pend_vec, 16'h0);
        rst_n = 1'b1; req_in = 16'h0;
        tick(3);

        // Random traffic against the model
        for (int r = 0; r < 400; r++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            ena        = ($urandom_range(0, 7) != 0);
            req_in     = req_in ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            mask_we    = ($urandom_range(0, 15) == 0);
            mask_wdata = 16'($urandom);
            clr_valid  = ($urandom_range(0, 2) == 0);
            clr_idx    = 4'($urandom);
            clr_all    = ($urandom_range(0, 31) == 0);
            ovf_clr    = ($urandom_range(0, 15) == 0);
            tick(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
